// File: rtl/score_keeper_pkg.sv
// Shared definitions for the score keeper: FSM encodings, BCD limits and default life counts.
package score_keeper_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PLAYING   = 2'd1,
        ST_GAME_OVER = 2'd2
    } state_e;

    localparam logic [3:0] BCD_MAX             = 4'd9;
    localparam logic [2:0] DEF_START_LIVES     = 3'd3;
    localparam logic [2:0] DEF_MAX_LIVES       = 3'd7;
    localparam bit         DEF_BONUS_ENABLE    = 1'b1;

    // Hit values above 9 are not legal BCD; treat them as a full 9.
    function automatic logic [3:0] clamp_bcd(input logic [3:0] v);
        return (v > BCD_MAX) ? BCD_MAX : v;
    endfunction

endpackage

// File: rtl/score_keeper_bcd_digit_add.sv
// Single BCD digit adder with carry in/out; decimal-adjusts any raw sum above 9.
module bcd_digit_add
    import score_keeper_pkg::*;
(
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       carry_i,
    output logic [3:0] sum_o,
    output logic       carry_o
);

    logic [4:0] raw;

    always_comb begin
        raw     = {1'b0, a_i} + {1'b0, b_i} + {4'b0000, carry_i};
        carry_o = (raw > {1'b0, BCD_MAX});
        sum_o   = carry_o ? (raw[3:0] + 4'd6) : raw[3:0];
    end

endmodule

// File: rtl/score_keeper.sv
// Game statistics bank: 3-digit saturating BCD score, lives counter with bonus
// lives, and the IDLE/PLAYING/GAME_OVER sequencing FSM.
//
//  state        | meaning
//  ST_IDLE      | after reset, waiting for the first new_game pulse
//  ST_PLAYING   | hits score points, ball losses consume lives
//  ST_GAME_OVER | lives exhausted, score frozen until new_game
module score_keeper
    import score_keeper_pkg::*;
#(
    parameter logic [2:0] START_LIVES  = DEF_START_LIVES,
    parameter logic [2:0] MAX_LIVES    = DEF_MAX_LIVES,
    parameter bit         BONUS_ENABLE = DEF_BONUS_ENABLE
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       new_game_i,
    input  logic       brick_hit_i,
    input  logic [3:0] brick_points_i,
    input  logic       ball_lost_i,
    output logic [3:0] score_100_o,
    output logic [3:0] score_10_o,
    output logic [3:0] score_1_o,
    output logic [2:0] lives_o,
    output logic       playing_o,
    output logic       game_over_o,
    output logic       bonus_life_o
);

    state_e     state_q, state_d;
    logic [3:0] d100_q, d100_d;
    logic [3:0] d10_q, d10_d;
    logic [3:0] d1_q, d1_d;
    logic [2:0] lives_q, lives_d;
    logic       bonus_q, bonus_d;

    logic [3:0] pts;
    logic [3:0] sum1, sum10, sum100;
    logic       c1, c10, c100;
    logic       hit_en, loss_en, bonus_en;

    assign pts = clamp_bcd(brick_points_i);

    bcd_digit_add u_add_1 (
        .a_i     (d1_q),
        .b_i     (pts),
        .carry_i (1'b0),
        .sum_o   (sum1),
        .carry_o (c1)
    );

    bcd_digit_add u_add_10 (
        .a_i     (d10_q),
        .b_i     (4'd0),
        .carry_i (c1),
        .sum_o   (sum10),
        .carry_o (c10)
    );

    bcd_digit_add u_add_100 (
        .a_i     (d100_q),
        .b_i     (4'd0),
        .carry_i (c10),
        .sum_o   (sum100),
        .carry_o (c100)
    );

    always_comb begin
        state_d = state_q;
        d100_d  = d100_q;
        d10_d   = d10_q;
        d1_d    = d1_q;
        lives_d = lives_q;
        bonus_d = 1'b0;

        hit_en   = (state_q == ST_PLAYING) && brick_hit_i && !new_game_i;
        loss_en  = (state_q == ST_PLAYING) && ball_lost_i && !new_game_i;
        // The hundreds digit only moves on a tens carry; a carry out of it means saturation.
        bonus_en = BONUS_ENABLE && hit_en && c10 && !c100;

        if (new_game_i) begin
            state_d = ST_PLAYING;
            d100_d  = 4'd0;
            d10_d   = 4'd0;
            d1_d    = 4'd0;
            lives_d = START_LIVES;
        end else begin
            if (hit_en) begin
                if (c100) begin
                    d100_d = BCD_MAX;
                    d10_d  = BCD_MAX;
                    d1_d   = BCD_MAX;
                end else begin
                    d100_d = sum100;
                    d10_d  = sum10;
                    d1_d   = sum1;
                end
            end

            bonus_d = bonus_en;

            if (bonus_en && loss_en) begin
                lives_d = lives_q;
            end else if (bonus_en) begin
                lives_d = (lives_q < MAX_LIVES) ? (lives_q + 3'd1) : MAX_LIVES;
            end else if (loss_en) begin
                lives_d = (lives_q != 3'd0) ? (lives_q - 3'd1) : 3'd0;
            end

            if (state_q == ST_PLAYING && lives_d == 3'd0) begin
                state_d = ST_GAME_OVER;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            d100_q  <= 4'd0;
            d10_q   <= 4'd0;
            d1_q    <= 4'd0;
            lives_q <= START_LIVES;
            bonus_q <= 1'b0;
        end else begin
            state_q <= state_d;
            d100_q  <= d100_d;
            d10_q   <= d10_d;
            d1_q    <= d1_d;
            lives_q <= lives_d;
            bonus_q <= bonus_d;
        end
    end

    assign score_100_o  = d100_q;
    assign score_10_o   = d10_q;
    assign score_1_o    = d1_q;
    assign lives_o      = lives_q;
    assign playing_o    = (state_q == ST_PLAYING);
    assign game_over_o  = (state_q == ST_GAME_OVER);
    assign bonus_life_o = bonus_q;

endmodule

// File: tb/tb_score_keeper.sv
// Directed self-checking bench for score_keeper.
module tb_score_keeper;

    logic       clk;
    logic       rst;
    logic       new_game;
    logic       brick_hit;
    logic [3:0] brick_points;
    logic       ball_lost;
    logic [3:0] s100, s10, s1;
    logic [2:0] lives;
    logic       playing, game_over, bonus;

    int n_cmp = 0;
    int n_bad = 0;

    score_keeper dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .new_game_i     (new_game),
        .brick_hit_i    (brick_hit),
        .brick_points_i (brick_points),
        .ball_lost_i    (ball_lost),
        .score_100_o    (s100),
        .score_10_o     (s10),
        .score_1_o      (s1),
        .lives_o        (lives),
        .playing_o      (playing),
        .game_over_o    (game_over),
        .bonus_life_o   (bonus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock with the given inputs; returns #1 after the sampling edge.
    task automatic pulse(input logic ng, input logic hit, input logic [3:0] pts, input logic lost);
        @(negedge clk);
        new_game     = ng;
        brick_hit    = hit;
        brick_points = pts;
        ball_lost    = lost;
        @(posedge clk);
        #1;
        new_game  = 1'b0;
        brick_hit = 1'b0;
        ball_lost = 1'b0;
    endtask

    task automatic add_points(input int total);
        int rem;
        rem = total;
        while (rem >= 9) begin
            pulse(1'b0, 1'b1, 4'd9, 1'b0);
            rem -= 9;
        end
        if (rem > 0) pulse(1'b0, 1'b1, rem[3:0], 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        new_game = 1'b0; brick_hit = 1'b0; brick_points = 4'd0; ball_lost = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if ({s100, s10, s1} !== 12'h000) begin n_bad++; $display("FAIL reset_score got=%h exp=000", {s100, s10, s1}); end
        n_cmp++; if (lives !== 3'd3) begin n_bad++; $display("FAIL reset_lives got=%0d exp=3", lives); end
        n_cmp++; if ({playing, game_over, bonus} !== 3'b000) begin n_bad++; $display("FAIL reset_flags got=%b exp=000", {playing, game_over, bonus}); end
        @(negedge clk);
        rst = 1'b0;
        pulse(1'b0, 1'b1, 4'd5, 1'b0);
        n_cmp++; if ({s100, s10, s1, playing} !== 13'h000_0) begin n_bad++; $display("FAIL idle_hit_ignored got=%h/%b exp=000/0", {s100, s10, s1}, playing); end
    endtask

    task automatic test_basic_score();
        pulse(1'b1, 1'b0, 4'd0, 1'b0);
        repeat (3) pulse(1'b0, 1'b1, 4'd4, 1'b0);
        n_cmp++; if ({s100, s10, s1} !== 12'h012) begin n_bad++; $display("FAIL basic_score got=%h exp=012", {s100, s10, s1}); end
        n_cmp++; if (lives !== 3'd3 || playing !== 1'b1) begin n_bad++; $display("FAIL basic_state got lives=%0d playing=%b exp 3/1", lives, playing); end
    endtask

    task automatic test_bonus();
        add_points(83);
        n_cmp++; if ({s100, s10, s1} !== 12'h095) begin n_bad++; $display("FAIL pre_bonus_score got=%h exp=095", {s100, s10, s1}); end
        pulse(1'b0, 1'b1, 4'd7, 1'b0);
        n_cmp++; if ({s100, s10, s1} !== 12'h102) begin n_bad++; $display("FAIL bonus_score got=%h exp=102", {s100, s10, s1}); end
        n_cmp++; if (bonus !== 1'b1) begin n_bad++; $display("FAIL bonus_pulse got=%b exp=1", bonus); end
        n_cmp++; if (lives !== 3'd4) begin n_bad++; $display("FAIL bonus_lives got=%0d exp=4", lives); end
        @(posedge clk); #1;
        n_cmp++; if (bonus !== 1'b0) begin n_bad++; $display("FAIL bonus_one_cycle got=%b exp=0", bonus); end
        add_points(98);   // 200 -> 5 lives
        add_points(100);  // 300 -> 6
        add_points(100);  // 400 -> 7
        n_cmp++; if ({s100, s10, s1, 1'b0, lives} !== {12'h400, 4'd7}) begin n_bad++; $display("FAIL climb got=%h lives=%0d exp=400 lives=7", {s100, s10, s1}, lives); end
        add_points(95);
        pulse(1'b0, 1'b1, 4'd7, 1'b0);
        n_cmp++; if ({s100, s10, s1} !== 12'h502 || bonus !== 1'b1) begin n_bad++; $display("FAIL capped_bonus got=%h bonus=%b exp=502 bonus=1", {s100, s10, s1}, bonus); end
        n_cmp++; if (lives !== 3'd7) begin n_bad++; $display("FAIL capped_lives got=%0d exp=7", lives); end
    endtask

    task automatic test_saturate();
        add_points(494);
        n_cmp++; if ({s100, s10, s1} !== 12'h996) begin n_bad++; $display("FAIL pre_sat got=%h exp=996", {s100, s10, s1}); end
        pulse(1'b0, 1'b1, 4'd9, 1'b0);
        n_cmp++; if ({s100, s10, s1} !== 12'h999 || bonus !== 1'b0) begin n_bad++; $display("FAIL saturate got=%h bonus=%b exp=999 bonus=0", {s100, s10, s1}, bonus); end
        pulse(1'b0, 1'b1, 4'd1, 1'b0);
        n_cmp++; if ({s100, s10, s1} !== 12'h999 || bonus !== 1'b0) begin n_bad++; $display("FAIL sat_hold got=%h bonus=%b exp=999 bonus=0", {s100, s10, s1}, bonus); end
    endtask

    task automatic test_game_over();
        repeat (6) pulse(1'b0, 1'b0, 4'd0, 1'b1);
        n_cmp++; if (lives !== 3'd1 || playing !== 1'b1) begin n_bad++; $display("FAIL lives_down got=%0d playing=%b exp=1/1", lives, playing); end
        pulse(1'b0, 1'b0, 4'd0, 1'b1);
        n_cmp++; if ({lives, playing, game_over} !== {3'd0, 2'b01}) begin n_bad++; $display("FAIL game_over got lives=%0d p=%b go=%b exp 0/0/1", lives, playing, game_over); end
        pulse(1'b0, 1'b1, 4'd3, 1'b1);
        n_cmp++; if ({s100, s10, s1} !== 12'h999 || lives !== 3'd0 || game_over !== 1'b1) begin n_bad++; $display("FAIL frozen got=%h lives=%0d go=%b exp=999/0/1", {s100, s10, s1}, lives, game_over); end
        pulse(1'b1, 1'b1, 4'd5, 1'b1);
        n_cmp++; if ({s100, s10, s1} !== 12'h000 || lives !== 3'd3 || playing !== 1'b1 || game_over !== 1'b0) begin n_bad++; $display("FAIL restart got=%h lives=%0d p=%b go=%b exp=000/3/1/0", {s100, s10, s1}, lives, playing, game_over); end
    endtask

    task automatic test_hit_and_loss();
        add_points(98);
        repeat (2) pulse(1'b0, 1'b0, 4'd0, 1'b1);
        n_cmp++; if ({s100, s10, s1} !== 12'h098 || lives !== 3'd1) begin n_bad++; $display("FAIL pre_combo got=%h lives=%0d exp=098/1", {s100, s10, s1}, lives); end
        pulse(1'b0, 1'b1, 4'd5, 1'b1);
        n_cmp++; if ({s100, s10, s1} !== 12'h103) begin n_bad++; $display("FAIL combo_score got=%h exp=103", {s100, s10, s1}); end
        n_cmp++; if (lives !== 3'd1 || playing !== 1'b1 || game_over !== 1'b0) begin n_bad++; $display("FAIL combo_lives got=%0d p=%b go=%b exp=1/1/0", lives, playing, game_over); end
    endtask

    task automatic test_clamp_and_async_reset();
        pulse(1'b1, 1'b0, 4'd0, 1'b0);
        pulse(1'b0, 1'b1, 4'hF, 1'b0);
        n_cmp++; if ({s100, s10, s1} !== 12'h009) begin n_bad++; $display("FAIL clamp got=%h exp=009", {s100, s10, s1}); end
        pulse(1'b0, 1'b1, 4'd0, 1'b0);
        n_cmp++; if ({s100, s10, s1} !== 12'h009) begin n_bad++; $display("FAIL zero_pts got=%h exp=009", {s100, s10, s1}); end
        pulse(1'b0, 1'b1, 4'd8, 1'b1);
        n_cmp++; if ({s100, s10, s1} !== 12'h017 || lives !== 3'd2) begin n_bad++; $display("FAIL pre_rst got=%h lives=%0d exp=017/2", {s100, s10, s1}, lives); end
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        n_cmp++; if ({s100, s10, s1} !== 12'h000 || lives !== 3'd3 || {playing, game_over, bonus} !== 3'b000) begin n_bad++; $display("FAIL async_rst got=%h lives=%0d flags=%b exp=000/3/000", {s100, s10, s1}, lives, {playing, game_over, bonus}); end
        @(negedge clk);
        rst = 1'b0;
        pulse(1'b0, 1'b1, 4'd4, 1'b0);
        n_cmp++; if ({s100, s10, s1} !== 12'h000 || playing !== 1'b0) begin n_bad++; $display("FAIL post_rst_idle got=%h p=%b exp=000/0", {s100, s10, s1}, playing); end
    endtask

    initial begin
        test_reset();
        test_basic_score();
        test_bonus();
        test_saturate();
        test_game_over();
        test_hit_and_loss();
        test_clamp_and_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
